// File: rtl/ifu_rom_responder.sv
// AXI-lite read-only responder serving instruction fetches from a preloadable 64-bit memory.
// Optional macro IFU_RESP_MISALIGN_CHECK_EN: in-window addresses with ARADDR[2:0] != 0 answer SLVERR.
module ifu_rom_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          LATENCY   = 1
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic [63:0]              IFU_ARADDR,
  input  logic [2:0]               IFU_ARPROT,
  input  logic                     IFU_ARVALID,
  output logic                     IFU_ARREADY,
  output logic [63:0]              IFU_RDATA,
  output logic [1:0]               IFU_RRESP,
  output logic                     IFU_RVALID,
  input  logic                     IFU_RREADY,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [63:0]              mem_wdata
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [3:0]  LAT_LOAD    = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  logic [63:0]   mem_q [DEPTH];
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    cls_q, cls_d;
  logic          arready_q, rvalid_q;
  logic [63:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  logic [63:0]   off_s;
  logic          hit_s;
  logic          ar_hs_s;
  logic [1:0]    ar_cls_s;
  logic          unused_s;

  assign off_s    = IFU_ARADDR - BASE_ADDR;
  assign hit_s    = (IFU_ARADDR >= BASE_ADDR) && ((off_s >> 3) < 64'(DEPTH));
  assign ar_hs_s  = IFU_ARVALID && arready_q;
  assign unused_s = ^IFU_ARPROT;

  assign IFU_ARREADY = arready_q;
  assign IFU_RVALID  = rvalid_q;
  assign IFU_RDATA   = rdata_q;
  assign IFU_RRESP   = rresp_q;

  // Response class of the address on the AR channel; DECERR outranks SLVERR.
  always_comb begin
    ar_cls_s = RESP_OKAY;
    if (!hit_s) begin
      ar_cls_s = RESP_DECERR;
    end
`ifdef IFU_RESP_MISALIGN_CHECK_EN
    else if (IFU_ARADDR[2:0] != 3'b000) begin
      ar_cls_s = RESP_SLVERR;
    end
`endif
    else begin
      ar_cls_s = RESP_OKAY;
    end
  end

  // Next-state logic plus the response capture on entry to RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cls_d   = cls_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    case (state_q)
      IDLE: begin
        if (ar_hs_s) begin
          idx_d = off_s[3 +: AW];
          cls_d = ar_cls_s;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = LAT_LOAD;
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (IFU_RREADY) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The memory read happens here, so a same-edge preload write is seen only by later reads.
    if ((state_d == RESP) && (state_q != RESP)) begin
      rresp_d = cls_d;
      rdata_d = (cls_d == RESP_OKAY) ? mem_q[idx_d] : 64'h0;
    end else begin
      rresp_d = rresp_q;
      rdata_d = rdata_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      cls_q     <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 64'h0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cls_q     <= cls_d;
      arready_q <= (state_d == IDLE);
      rvalid_q  <= (state_d == RESP);
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Preload write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_ifu_rom_responder.sv
// Self-checking bench for ifu_rom_responder: directed plan steps plus randomized reads against a model.
module tb_ifu_rom_responder;

  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          LAT   = 1;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [63:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        IFU_ARREADY;
  logic [63:0] IFU_RDATA;
  logic [1:0]  IFU_RRESP;
  logic        IFU_RVALID;
  logic        RREADY;
  logic        mem_we;
  logic [9:0]  mem_waddr;
  logic [63:0] mem_wdata;

  logic [63:0] model_mem [DEPTH];
  int total = 0;
  int bad   = 0;

  ifu_rom_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .IFU_ARADDR(ARADDR), .IFU_ARPROT(ARPROT), .IFU_ARVALID(ARVALID), .IFU_ARREADY(IFU_ARREADY),
    .IFU_RDATA(IFU_RDATA), .IFU_RRESP(IFU_RRESP), .IFU_RVALID(IFU_RVALID), .IFU_RREADY(RREADY),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: window is [BASE, BASE + DEPTH*8); each doubleword is one entry.
  function automatic logic [65:0] model_read(input logic [63:0] a);
    logic [63:0] lim;
    lim = BASE + 64'(DEPTH) * 64'd8;
    if (a < BASE || a >= lim) return {2'b11, 64'd0};
`ifdef IFU_RESP_MISALIGN_CHECK_EN
    if (a[2:0] != 3'b000) return {2'b10, 64'd0};
`endif
    return {2'b00, model_mem[int'((a - BASE) / 64'd8)]};
  endfunction

  task automatic preload(input int idx, input logic [63:0] d);
    @(negedge CLK);
    mem_we = 1'b1; mem_waddr = 10'(idx); mem_wdata = d;
    @(negedge CLK);
    mem_we = 1'b0;
    model_mem[idx] = d;
  endtask

  task automatic do_read(input logic [63:0] a, input int stall, input logic cw,
                         input logic [63:0] cw_data, input string tag);
    logic [65:0] e;
    logic [63:0] off;
    int n;
    int cycles;
    e   = model_read(a);
    off = a - BASE;
    RREADY = 1'b0;
    @(negedge CLK);
    ARADDR = a; ARVALID = 1'b1; ARPROT = 3'($urandom);
    n = 0;
    while (IFU_ARREADY !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, " arready"}, 64'(IFU_ARREADY), 64'd1);
    @(negedge CLK);
    ARVALID = 1'b0;
    ARADDR  = {$urandom, $urandom};
    chk({tag, " arready_low"}, 64'(IFU_ARREADY), 64'd0);
    cycles = 1;
    for (int g = 0; g < 40; g++) begin
      if (cw && cycles == LAT) begin
        mem_we = 1'b1; mem_waddr = off[12:3]; mem_wdata = cw_data;
      end else begin
        mem_we = 1'b0;
      end
      if (IFU_RVALID === 1'b1) break;
      @(negedge CLK);
      cycles++;
    end
    mem_we = 1'b0;
    if (cw) model_mem[int'(off[12:3])] = cw_data;
    chk({tag, " latency"}, 64'(cycles), 64'(LAT + 1));
    chk({tag, " rdata"}, IFU_RDATA, e[63:0]);
    chk({tag, " rresp"}, 64'(IFU_RRESP), 64'(e[65:64]));
    for (int i = 0; i < stall; i++) begin
      @(negedge CLK);
      chk({tag, " stall_rvalid"}, 64'(IFU_RVALID), 64'd1);
      chk({tag, " stall_rdata"}, IFU_RDATA, e[63:0]);
      chk({tag, " stall_rresp"}, 64'(IFU_RRESP), 64'(e[65:64]));
    end
    RREADY = 1'b1;
    @(negedge CLK);
    RREADY = 1'b0;
    chk({tag, " rvalid_done"}, 64'(IFU_RVALID), 64'd0);
    chk({tag, " arready_back"}, 64'(IFU_ARREADY), 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    int kind;
    RSTn = 1'b0; ARADDR = BASE; ARPROT = 3'd0; ARVALID = 1'b1; RREADY = 1'b0;
    mem_we = 1'b0; mem_waddr = 10'd0; mem_wdata = 64'd0;

    // Reset values, ARVALID held during reset must not be accepted.
    repeat (3) @(negedge CLK);
    chk("rst arready", 64'(IFU_ARREADY), 64'd0);
    chk("rst rvalid", 64'(IFU_RVALID), 64'd0);
    chk("rst rdata", IFU_RDATA, 64'd0);
    chk("rst rresp", 64'(IFU_RRESP), 64'd0);
    RSTn = 1'b1;
    chk("rel arready_pre", 64'(IFU_ARREADY), 64'd0);
    @(negedge CLK);
    chk("rel arready_first_edge", 64'(IFU_ARREADY), 64'd1);
    ARVALID = 1'b0;
    @(negedge CLK);
    chk("rel arready_hold", 64'(IFU_ARREADY), 64'd1);
    chk("rel rvalid", 64'(IFU_RVALID), 64'd0);

    for (int i = 0; i < DEPTH; i++) preload(i, {$urandom, $urandom});
    preload(0, 64'h0013_0000_0000_0093);
    preload(1, 64'h1111_2222_3333_4444);

    do_read(64'h8000_0000, 0, 1'b0, 64'd0, "rd_e0");
    chk("rd_e0 const", model_mem[0], 64'h0013_0000_0000_0093);
    do_read(64'h8000_0008, 5, 1'b0, 64'd0, "rd_stall");
    do_read(64'h7FFF_FFF8, 0, 1'b0, 64'd0, "below");
    do_read(64'h8000_2000, 1, 1'b0, 64'd0, "above");
    do_read(64'h8000_1FF8, 0, 1'b0, 64'd0, "last");
    do_read(64'hFFFF_FFFF_FFFF_FFF8, 0, 1'b0, 64'd0, "top");
    do_read(64'h0, 0, 1'b0, 64'd0, "zero");
    do_read(64'h8000_0004, 0, 1'b0, 64'd0, "misalign");

    // Read-before-write collision, then the new value is visible.
    preload(2, 64'hBBBB_0000_BBBB_0002);
    do_read(64'h8000_0010, 0, 1'b1, 64'hAAAA_1111_AAAA_0002, "coll_old");
    do_read(64'h8000_0010, 0, 1'b0, 64'd0, "coll_new");

    // Reset while the read is in WAIT drops it.
    @(negedge CLK);
    ARADDR = 64'h8000_0008; ARVALID = 1'b1;
    for (int n = 0; n < 20 && IFU_ARREADY !== 1'b1; n++) @(negedge CLK);
    @(negedge CLK);
    ARVALID = 1'b0;
    RSTn = 1'b0;
    #1;
    chk("midrst rvalid", 64'(IFU_RVALID), 64'd0);
    chk("midrst arready", 64'(IFU_ARREADY), 64'd0);
    chk("midrst rdata", IFU_RDATA, 64'd0);
    repeat (2) @(negedge CLK);
    chk("midrst rvalid_hold", 64'(IFU_RVALID), 64'd0);
    RSTn = 1'b1;
    chk("midrst arready_pre", 64'(IFU_ARREADY), 64'd0);
    @(negedge CLK);
    chk("midrst arready_post", 64'(IFU_ARREADY), 64'd1);
    repeat (3) begin
      @(negedge CLK);
      chk("midrst dropped", 64'(IFU_RVALID), 64'd0);
    end
    do_read(64'h8000_0008, 0, 1'b0, 64'd0, "after_rst");

    // Randomized reads across window classes with random stalls and preload traffic.
    for (int t = 0; t < 80; t++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: a = BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
        1: a = BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
        2: a = BASE - 64'($urandom_range(1, 4096));
        3: a = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 4096));
        default: a = {$urandom, $urandom};
      endcase
      if ($urandom_range(0, 3) == 0) preload(int'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
      do_read(a, int'($urandom_range(0, 3)), (kind <= 1) && ($urandom_range(0, 3) == 0),
              {$urandom, $urandom}, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
